// File: rtl/plru_icache.sv
// Read-only set-associative line cache with tree-PLRU replacement, a miss FSM,
// single-cycle flush and saturating hit/miss counters.
module plru_icache #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_SIZE = 256,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  output logic [LINE_SIZE-1:0] mem_rdata,
  output logic                 mem_resp,
  input  logic                 flush,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  input  logic [LINE_SIZE-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int unsigned S_OFFSET = $clog2(LINE_SIZE / 8);
  localparam int unsigned S_INDEX  = $clog2(SETS);
  localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned S_WAY    = $clog2(WAYS);
  localparam logic [31:0] OFF_MASK = 32'(LINE_SIZE / 8 - 1);

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_e;

  state_e                state_q, state_d;
  logic [LINE_SIZE-1:0]  mem_rdata_q, mem_rdata_d;
  logic                  mem_resp_q, mem_resp_d;
  logic [31:0]           pmem_address_q, pmem_address_d;
  logic                  pmem_read_q, pmem_read_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic [S_TAG-1:0]      miss_tag_q, miss_tag_d;
  logic [S_INDEX-1:0]    miss_idx_q, miss_idx_d;
  logic                  flush_pend_q, flush_pend_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;
  logic [LINE_SIZE-1:0]      data_q [SETS][WAYS];
  logic [S_TAG-1:0]          tag_q  [SETS][WAYS];

  logic [S_TAG-1:0]     req_tag;
  logic [S_INDEX-1:0]   req_idx;
  logic                 hit;
  logic [S_WAY-1:0]     hit_way;
  logic                 inv_found;
  logic [S_WAY-1:0]     inv_way;
  logic [S_WAY-1:0]     victim;
  logic                 fill_we;
  logic                 plru_we;
  logic [S_INDEX-1:0]   plru_set;
  logic [S_WAY-1:0]     plru_way;
  logic                 clear_all;

  // Root node splits on way bit 0, next level on bit 1, and so on.
  function automatic logic [S_WAY-1:0] plru_victim(input logic [WAYS-2:0] t);
    logic [S_WAY-1:0] n;
    logic [S_WAY-1:0] v;
    n = '0;
    v = '0;
    for (int l = 0; l < S_WAY; l++) begin
      v[l] = t[n];
      n    = S_WAY'(32'(n) * 32'd2 + 32'd1 + {31'b0, t[n]});
    end
    return v;
  endfunction

  // Point every node on the accessed path away from the accessed way.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                  input logic [S_WAY-1:0] w);
    logic [S_WAY-1:0] n;
    logic [WAYS-2:0]  r;
    n = '0;
    r = t;
    for (int l = 0; l < S_WAY; l++) begin
      r[n] = ~w[l];
      n    = S_WAY'(32'(n) * 32'd2 + 32'd1 + {31'b0, w[l]});
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign req_tag = mem_address[31 -: S_TAG];
  assign req_idx = mem_address[S_OFFSET +: S_INDEX];

  // Combinational tag lookup on the live request address.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = S_WAY'(w);
      end
    end
  end

  // Victim: lowest invalid way in the latched set, else the PLRU choice.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[miss_idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = S_WAY'(w);
      end
    end
    victim = inv_found ? inv_way : plru_victim(plru_q[miss_idx_q]);
  end

  always_comb begin
    state_d        = state_q;
    mem_rdata_d    = mem_rdata_q;
    mem_resp_d     = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_read_d    = pmem_read_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    miss_tag_d     = miss_tag_q;
    miss_idx_d     = miss_idx_q;
    flush_pend_d   = flush_pend_q;
    fill_we        = 1'b0;
    plru_we        = 1'b0;
    plru_set       = req_idx;
    plru_way       = hit_way;
    clear_all      = 1'b0;
    case (state_q)
      IDLE: begin
        clear_all = flush;
        if (mem_read) begin
          if (hit) begin
            mem_rdata_d = data_q[req_idx][hit_way];
            mem_resp_d  = 1'b1;
            hit_cnt_d   = sat_inc(hit_cnt_q);
            plru_we     = 1'b1;
            state_d     = RESP;
          end else begin
            miss_tag_d     = req_tag;
            miss_idx_d     = req_idx;
            pmem_address_d = mem_address & ~OFF_MASK;
            pmem_read_d    = 1'b1;
            state_d        = MISS;
          end
        end
      end
      MISS: begin
        if (flush) flush_pend_d = 1'b1;
        if (pmem_resp) begin
          fill_we      = 1'b1;
          plru_we      = 1'b1;
          plru_set     = miss_idx_q;
          plru_way     = victim;
          mem_rdata_d  = pmem_rdata;
          mem_resp_d   = 1'b1;
          pmem_read_d  = 1'b0;
          miss_cnt_d   = sat_inc(miss_cnt_q);
          clear_all    = flush_pend_q | flush;
          flush_pend_d = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        clear_all = flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_address_q <= '0;
      pmem_read_q    <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      miss_tag_q     <= '0;
      miss_idx_q     <= '0;
      flush_pend_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= mem_resp_d;
      pmem_address_q <= pmem_address_d;
      pmem_read_q    <= pmem_read_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      miss_tag_q     <= miss_tag_d;
      miss_idx_q     <= miss_idx_d;
      flush_pend_q   <= flush_pend_d;
    end
  end

  // Flush wins over any same-cycle valid/PLRU update, including a fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      if (fill_we) valid_q[miss_idx_q][victim] <= 1'b1;
      if (plru_we) plru_q[plru_set] <= plru_touch(plru_q[plru_set], plru_way);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[miss_idx_q][victim] <= pmem_rdata;
      tag_q[miss_idx_q][victim]  <= miss_tag_q;
    end
  end

  assign mem_rdata    = mem_rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_address = pmem_address_q;
  assign pmem_read    = pmem_read_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_plru_icache.sv
// Directed bench for plru_icache: a table of read transactions plus hand-written
// sequences for mid-miss address change, flush and reset.
module tb_plru_icache;

  localparam int unsigned LS   = 256;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic [LS-1:0] mem_rdata;
  logic          mem_resp;
  logic          flush;
  logic [31:0]   pmem_address;
  logic          pmem_read;
  logic [LS-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_h, exp_m;

  plru_icache #(.WAYS(4), .SETS(16), .LINE_SIZE(LS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .flush(flush),
    .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          dly;
    int          seed;
    bit          exp_miss;
    int          exp_seed;
    int          exp_h;
    int          exp_m;
  } vec_t;

  function automatic logic [LS-1:0] mk_line(input int seed);
    logic [31:0] s;
    s = 32'hC0DE_0000 | 32'(seed);
    return {8{s}} ^ {224'b0, 32'(seed) << 8};
  endfunction

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [LS-1:0] act, input logic [LS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  // One read transaction; serves the fill after dly cycles of pmem_read.
  task automatic run_txn(input string tag, input logic [31:0] addr, input int dly,
                         input int seed, input bit exp_miss, input int exp_seed,
                         input int eh, input int em);
    bit            miss, done;
    int            lat, pcnt;
    logic [31:0]   paddr;
    logic [LS-1:0] line;
    miss = 1'b0; done = 1'b0; lat = 0; pcnt = 0; paddr = '0; line = '0;
    @(negedge clk);
    mem_address = addr;
    mem_read    = 1'b1;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp) begin
        done = 1'b1; lat = k; line = mem_rdata; mem_read = 1'b0;
      end else if (pmem_read) begin
        if (!miss) paddr = pmem_address;
        miss = 1'b1;
        pcnt++;
        if (pcnt == dly) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mk_line(seed);
        end
      end
    end
    mem_read = 1'b0;
    chk(tag, "responded", LS'(done), LS'(1));
    chk(tag, "missed", LS'(miss), LS'(exp_miss));
    chk(tag, "latency", LS'(lat), LS'(exp_miss ? dly + 1 : 1));
    chk(tag, "rdata", line, mk_line(exp_seed));
    if (exp_miss) chk(tag, "pmem_address", LS'(paddr), LS'(addr & 32'hFFFF_FFE0));
    chk(tag, "pmem_read_low", LS'(pmem_read), LS'(0));
    chk(tag, "hit_count", LS'(hit_count), LS'(eh));
    chk(tag, "miss_count", LS'(miss_count), LS'(em));
  endtask

  vec_t vecs[18];

  initial begin
    // Set 2 holds tags A=0x040 B=0x240 C=0x440 D=0x640 E=0x840.
    vecs[0]  = '{32'h0000_0040, 5, 1, 1'b1, 1, 0, 1};
    vecs[1]  = '{32'h0000_0044, 0, 0, 1'b0, 1, 1, 1};
    vecs[2]  = '{32'h0000_0240, 2, 2, 1'b1, 2, 1, 2};
    vecs[3]  = '{32'h0000_0440, 1, 3, 1'b1, 3, 1, 3};
    vecs[4]  = '{32'h0000_0640, 3, 4, 1'b1, 4, 1, 4};
    vecs[5]  = '{32'h0000_0040, 0, 0, 1'b0, 1, 2, 4};
    vecs[6]  = '{32'h0000_0840, 2, 5, 1'b1, 5, 2, 5};
    vecs[7]  = '{32'h0000_0040, 0, 0, 1'b0, 1, 3, 5};
    vecs[8]  = '{32'h0000_0448, 0, 0, 1'b0, 3, 4, 5};
    vecs[9]  = '{32'h0000_065C, 0, 0, 1'b0, 4, 5, 5};
    vecs[10] = '{32'h0000_0240, 1, 6, 1'b1, 6, 5, 6};
    vecs[11] = '{32'h0000_0840, 0, 0, 1'b0, 5, 6, 6};
    vecs[12] = '{32'h0000_1000, 4, 7, 1'b1, 7, 6, 7};
    vecs[13] = '{32'h0000_101C, 0, 0, 1'b0, 7, 7, 7};
    vecs[14] = '{32'h0000_1004, 0, 0, 1'b0, 7, 7, 7};
    vecs[15] = '{32'h0000_2000, 1, 8, 1'b1, 8, 7, 7};
    vecs[16] = '{32'h0000_0040, 1, 9, 1'b1, 9, 7, 7};
    vecs[17] = '{32'h0000_0440, 1, 10, 1'b1, 10, 7, 7};

    rst = 1'b1; mem_address = '0; mem_read = 1'b0; flush = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", "mem_resp", LS'(mem_resp), LS'(0));
    chk("reset", "pmem_read", LS'(pmem_read), LS'(0));
    chk("reset", "mem_rdata", mem_rdata, LS'(0));
    chk("reset", "pmem_address", LS'(pmem_address), LS'(0));
    chk("reset", "hit_count", LS'(hit_count), LS'(0));
    chk("reset", "miss_count", LS'(miss_count), LS'(0));
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dly, vecs[i].seed,
              vecs[i].exp_miss, vecs[i].exp_seed, vecs[i].exp_h, vecs[i].exp_m);
    exp_h = 7; exp_m = 7;

    // Flush in IDLE: previously resident lines all miss.
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    exp_m = sat(exp_m);
    run_txn("idle_flush_e", 32'h0000_0840, 1, 11, 1'b1, 11, exp_h, exp_m);
    exp_m = sat(exp_m);
    run_txn("idle_flush_x", 32'h0000_1000, 2, 12, 1'b1, 12, exp_h, exp_m);

    // Address change while in MISS: latched address and set are used.
    @(negedge clk); mem_address = 32'h0000_00A0; mem_read = 1'b1;
    @(negedge clk);
    chk("addr_chg", "pmem_read", LS'(pmem_read), LS'(1));
    chk("addr_chg", "pmem_address", LS'(pmem_address), LS'(32'h0000_00A0));
    mem_address = 32'h0000_0FE0;
    @(negedge clk);
    chk("addr_chg", "pmem_address_held", LS'(pmem_address), LS'(32'h0000_00A0));
    pmem_resp = 1'b1; pmem_rdata = mk_line(20);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("addr_chg", "mem_resp", LS'(mem_resp), LS'(1));
    chk("addr_chg", "mem_rdata", mem_rdata, mk_line(20));
    mem_read = 1'b0;
    exp_m = sat(exp_m);
    exp_h = sat(exp_h);
    run_txn("addr_chg_hit", 32'h0000_00A4, 0, 0, 1'b0, 20, exp_h, exp_m);

    // Flush during MISS: data still returned, line then invalid.
    @(negedge clk); mem_address = 32'h0000_00C0; mem_read = 1'b1;
    @(negedge clk);
    chk("miss_flush", "pmem_read", LS'(pmem_read), LS'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("miss_flush", "pmem_read_held", LS'(pmem_read), LS'(1));
    pmem_resp = 1'b1; pmem_rdata = mk_line(21);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("miss_flush", "mem_resp", LS'(mem_resp), LS'(1));
    chk("miss_flush", "mem_rdata", mem_rdata, mk_line(21));
    mem_read = 1'b0;
    exp_m = sat(exp_m);
    exp_m = sat(exp_m);
    run_txn("miss_flush_re", 32'h0000_00C0, 2, 22, 1'b1, 22, exp_h, exp_m);
    exp_m = sat(exp_m);
    run_txn("miss_flush_a0", 32'h0000_00A0, 1, 23, 1'b1, 23, exp_h, exp_m);

    // Hit in the same cycle as a flush completes with pre-flush contents.
    @(negedge clk); mem_address = 32'h0000_00C0; mem_read = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_hit", "mem_resp", LS'(mem_resp), LS'(1));
    chk("flush_hit", "mem_rdata", mem_rdata, mk_line(22));
    mem_read = 1'b0;
    exp_h = sat(exp_h);
    exp_m = sat(exp_m);
    run_txn("flush_hit_re", 32'h0000_00C0, 1, 24, 1'b1, 24, exp_h, exp_m);

    // Reset mid-miss: pmem_read drops asynchronously, late fill ignored.
    @(negedge clk); mem_address = 32'h0000_0040; mem_read = 1'b1;
    @(negedge clk);
    chk("rst_miss", "pmem_read", LS'(pmem_read), LS'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_miss", "pmem_read_async", LS'(pmem_read), LS'(0));
    chk("rst_miss", "miss_count_async", LS'(miss_count), LS'(0));
    mem_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = mk_line(30);
    @(negedge clk);
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("rst_miss", "mem_resp", LS'(mem_resp), LS'(0));
    chk("rst_miss", "pmem_read_idle", LS'(pmem_read), LS'(0));
    chk("rst_miss", "hit_count", LS'(hit_count), LS'(0));
    chk("rst_miss", "miss_count", LS'(miss_count), LS'(0));
    run_txn("rst_miss_re", 32'h0000_0040, 2, 31, 1'b1, 31, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
